ff_fifo_replay_pow2_depth: RTL and testbench
============================================

# ff_fifo_replay_pow2_depth

AXI-stream flop-based FIFO with read-side replay, depth 2**A_WIDTH. Words stay stored after being popped until the downstream consumer acknowledges complete packets. A negative acknowledge rewinds the read pointer so every unacknowledged word is sent again. It sits on the transmit side of a link as a retransmit buffer, mirroring the write-side rollback FIFO used on the receive path.

## Interface
- D_WIDTH, 6: data width; bit D_WIDTH-1 is tlast, the remaining bits are payload.
- A_WIDTH, 3: address width; depth = 2**A_WIDTH. A_WIDTH ≥ 1.

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- up_data  in  D_WIDTH  write data, tlast at MSB.
- up_valid  in  1  write valid.
- up_ready  out  1  write ready (not full).
- down_data  out  D_WIDTH  read data = ram[rd_ptr], combinational.
- down_valid  out  1  read valid (unread word present).
- down_ready  in  1  read ready.
- down_ack  in  1  single-cycle pulse: commit all fully popped packets.
- down_nack  in  1  single-cycle pulse: replay from oldest uncommitted word.
- pending  out  1  popped-but-uncommitted words exist.

## Operation
- Four (A_WIDTH+1)-bit pointers, with the MSB as the wrap bit: wr_ptr, rd_ptr (speculative), commit_ptr (oldest uncommitted word), bound_ptr (rd_ptr value just after the most recent popped tlast). All reset to 0.
- push = up_valid & up_ready. On push, write ram[wr_ptr[A_WIDTH-1:0]] and increment wr_ptr.
- pop = down_valid & down_ready. On pop, increment rd_ptr. If the popped word has tlast = 1, bound_next = rd_ptr+1; otherwise bound_next = bound_ptr.
- ack without nack: commit_ptr <= bound_next. A tlast popped in the same cycle is included. A partially popped packet is never committed.
- nack: rd_ptr <= commit_ptr and bound_ptr <= commit_ptr. nack overrides a same-cycle pop and ack.
  - The pop handshake still completes, but the beat is discarded by protocol and re-sent.
  - A same-cycle ack is ignored.
- Full: wr_ptr and commit_ptr have different MSBs and equal LSBs. up_ready = ~full. Popped but unacked words still occupy space.
- Empty: wr_ptr == rd_ptr. down_valid = ~empty.
- pending = (rd_ptr != commit_ptr).
- Invariant order, modulo wrap: commit_ptr ≤ bound_ptr ≤ rd_ptr ≤ wr_ptr.
  - ack with no new boundary leaves commit_ptr unchanged.
  - nack with nothing pending is a no-op.
- Push and pop in the same cycle are independent, including when nack rewinds rd_ptr.

## Timing
- Reset values: up_ready = 1, down_valid = 0, pending = 0. down_data = ram[0], undefined content.
- Write-to-read latency is 1 cycle: a word pushed in cycle N gives down_valid = 1 in cycle N+1.
- Ack-to-space latency is 1 cycle: up_ready rises in the cycle after the committing ack.
- nack takes effect next cycle. down_data then shows the word at the old commit_ptr, and down_valid = 1 if any word was pending.
- Wrap-around: pointers roll over at 2**(A_WIDTH+1), with no special handling.
- Reset mid-packet or mid-replay discards all contents and pointers; no partial state survives.
- down_data is only meaningful while down_valid = 1. It must stay stable while down_valid & ~down_ready.

## Test plan
- Packet commit:
  - Stimulus: push 3 words (tlast on the 3rd), pop all 3, then pulse ack.
  - Before ack: pending = 1, up_ready = 1.
  - Cycle after ack: pending = 0, commit_ptr = 3.
- Replay:
  - Stimulus: push packet A0, A1, A2(tlast); pop all 3; pulse nack.
  - Required: the next 3 pops return A0, A1, A2 in order; then ack gives pending = 0.
- Partial-packet ack:
  - Stimulus: push P0(tlast), Q0, Q1(tlast); pop P0 and Q0; ack.
  - Required: commit_ptr = 1. After a subsequent nack, the next pop returns Q0.
- Full via unacked data:
  - Stimulus: push 8 single-word packets, pop all 8 without ack.
  - Required: up_ready = 0 and down_valid = 0.
  - Then ack: up_ready = 1 next cycle. Push 8 more words: pointers wrap and the data is correct.
- Simultaneous events:
  - Same-cycle pop of a tlast word with ack: commit includes that packet.
  - Same-cycle pop with nack and ack: rd_ptr = commit_ptr, ack ignored, and the popped beat is re-sent.
- Reset mid-replay:
  - Stimulus: assert rst after a nack with 2 words pending.
  - Required next cycle: down_valid = 0, pending = 0, up_ready = 1.

Source files
------------

// File: rtl/ff_fifo_replay_pow2_depth.sv
// ff_fifo_replay_pow2_depth
//
// Flop-based AXI-stream FIFO with read-side replay. Popped words stay resident
// until the consumer acknowledges whole packets. A nack rewinds the read side
// so that every unacknowledged word is sent again. Depth is 2**A_WIDTH.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   up_data    in   write data, tlast at MSB
//   up_valid   in   write valid
//   up_ready   out  write ready (not full; unacked words still occupy space)
//   down_data  out  read data = ram[rd_ptr], combinational
//   down_valid out  unread word present
//   down_ready in   read ready
//   down_ack   in   pulse: commit every fully popped packet
//   down_nack  in   pulse: replay from oldest uncommitted word (wins over ack)
//   pending    out  popped-but-uncommitted words exist
module ff_fifo_replay_pow2_depth #(
    parameter int unsigned D_WIDTH = 6,
    parameter int unsigned A_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    input  logic               down_ack,
    input  logic               down_nack,
    output logic               pending
);

    localparam int unsigned DEPTH = 2 ** A_WIDTH;
    localparam int unsigned PW    = A_WIDTH + 1;

    logic [D_WIDTH-1:0] ram [DEPTH];

    // All pointers carry an extra wrap bit in the MSB.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] bound_ptr_q, bound_ptr_d;
    logic [PW-1:0] bound_next;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Space is reclaimed only on commit, so fullness is judged against commit_ptr.
    assign full  = (wr_ptr_q[A_WIDTH] != commit_ptr_q[A_WIDTH]) &&
                   (wr_ptr_q[A_WIDTH-1:0] == commit_ptr_q[A_WIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign up_ready   = ~full;
    assign down_valid = ~empty;
    assign pending    = (rd_ptr_q != commit_ptr_q);
    assign down_data  = ram[rd_ptr_q[A_WIDTH-1:0]];

    assign push = up_valid & up_ready;
    assign pop  = down_valid & down_ready;

    // Boundary including a tlast popped this very cycle, so a same-cycle ack
    // commits that packet too.
    always_comb begin
        bound_next = bound_ptr_q;
        if (pop && down_data[D_WIDTH-1]) begin
            bound_next = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        commit_ptr_d = commit_ptr_q;
        bound_ptr_d  = bound_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (down_nack) begin
            // Any beat handshaken this cycle is dropped and will be re-sent.
            rd_ptr_d    = commit_ptr_q;
            bound_ptr_d = commit_ptr_q;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            bound_ptr_d = bound_next;
            if (down_ack) begin
                commit_ptr_d = bound_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            commit_ptr_q <= '0;
            bound_ptr_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            bound_ptr_q  <= bound_ptr_d;
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ram[wr_ptr_q[A_WIDTH-1:0]] <= up_data;
        end
    end

endmodule

// File: tb/tb_ff_fifo_replay_pow2_depth.sv
module tb_ff_fifo_replay_pow2_depth;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic [5:0] down_data;
    logic       down_valid;
    logic       down_ready;
    logic       down_ack;
    logic       down_nack;
    logic       pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ff_fifo_replay_pow2_depth #(
        .D_WIDTH(6),
        .A_WIDTH(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .down_data (down_data),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .down_ack  (down_ack),
        .down_nack (down_nack),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] d);
        up_valid = 1'b1;
        up_data  = d;
        tick();
        up_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [5:0] exp);
        down_ready = 1'b1;
        #1;
        check({tag, ".valid"}, 32'(down_valid), 32'd1);
        check({tag, ".data"}, 32'(down_data), 32'(exp));
        tick();
        down_ready = 1'b0;
    endtask

    task automatic pulse_ack();
        down_ack = 1'b1;
        tick();
        down_ack = 1'b0;
    endtask

    task automatic pulse_nack();
        down_nack = 1'b1;
        tick();
        down_nack = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        up_data    = '0;
        up_valid   = 1'b0;
        down_ready = 1'b0;
        down_ack   = 1'b0;
        down_nack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst.up_ready", 32'(up_ready), 32'd1);
        check("rst.down_valid", 32'(down_valid), 32'd0);
        check("rst.pending", 32'(pending), 32'd0);

        // Packet commit: 3 words, tlast on the 3rd.
        push(6'h01);
        check("lat.down_valid", 32'(down_valid), 32'd1);
        push(6'h02);
        push(6'h23);
        pop_expect("c0", 6'h01);
        pop_expect("c1", 6'h02);
        pop_expect("c2", 6'h23);
        check("c.pending_pre", 32'(pending), 32'd1);
        check("c.up_ready_pre", 32'(up_ready), 32'd1);
        pulse_ack();
        check("c.pending_post", 32'(pending), 32'd0);
        check("c.down_valid_post", 32'(down_valid), 32'd0);
        // Nothing pending: nack must not resurrect committed words.
        pulse_nack();
        check("c.nack_noop_valid", 32'(down_valid), 32'd0);
        check("c.nack_noop_pending", 32'(pending), 32'd0);

        // Replay a whole packet.
        push(6'h04);
        push(6'h05);
        push(6'h26);
        pop_expect("r0", 6'h04);
        pop_expect("r1", 6'h05);
        pop_expect("r2", 6'h26);
        pulse_nack();
        check("r.valid_after_nack", 32'(down_valid), 32'd1);
        check("r.data_after_nack", 32'(down_data), 32'h04);
        check("r.pending_after_nack", 32'(pending), 32'd0);
        pop_expect("rr0", 6'h04);
        pop_expect("rr1", 6'h05);
        pop_expect("rr2", 6'h26);
        check("r.pending_pre_ack", 32'(pending), 32'd1);
        pulse_ack();
        check("r.pending_post_ack", 32'(pending), 32'd0);

        // Partial-packet ack commits only P.
        push(6'h27);
        push(6'h08);
        push(6'h29);
        pop_expect("p.P0", 6'h27);
        pop_expect("p.Q0", 6'h08);
        pulse_ack();
        check("p.pending_after_ack", 32'(pending), 32'd1);
        pulse_nack();
        pop_expect("p.Q0_replay", 6'h08);
        pop_expect("p.Q1", 6'h29);
        pulse_ack();
        check("p.pending_final", 32'(pending), 32'd0);

        // Full via unacked data, then wrap.
        for (int i = 0; i < 8; i++) begin
            check("f.up_ready_fill", 32'(up_ready), 32'd1);
            push(6'h20 | 6'(i));
        end
        check("f.full_after_fill", 32'(up_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pop_expect("f.pop", 6'h20 | 6'(i));
        end
        check("f.full_unacked", 32'(up_ready), 32'd0);
        check("f.empty_unacked", 32'(down_valid), 32'd0);
        check("f.pending_unacked", 32'(pending), 32'd1);
        pulse_ack();
        check("f.up_ready_after_ack", 32'(up_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            push(6'h30 | 6'(i));
        end
        check("f.full_again", 32'(up_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            pop_expect("f.wrap_pop", 6'h30 | 6'(i));
        end
        pulse_ack();
        check("f.wrap_pending", 32'(pending), 32'd0);
        check("f.wrap_up_ready", 32'(up_ready), 32'd1);

        // Same-cycle pop of tlast with ack commits that packet.
        push(6'h01);
        push(6'h22);
        pop_expect("s.a0", 6'h01);
        down_ack = 1'b1;
        pop_expect("s.a1_with_ack", 6'h22);
        down_ack = 1'b0;
        check("s.pending_after_pop_ack", 32'(pending), 32'd0);

        // Pop + nack + ack + push in one cycle.
        push(6'h03);
        push(6'h24);
        pop_expect("s.b0", 6'h03);
        down_nack = 1'b1;
        down_ack  = 1'b1;
        up_valid  = 1'b1;
        up_data   = 6'h25;
        pop_expect("s.b1_with_nack", 6'h24);
        down_nack = 1'b0;
        down_ack  = 1'b0;
        up_valid  = 1'b0;
        check("s.pending_after_nack", 32'(pending), 32'd0);
        check("s.data_after_nack", 32'(down_data), 32'h03);
        pop_expect("s.b0_replay", 6'h03);
        pop_expect("s.b1_replay", 6'h24);
        pop_expect("s.push_during_nack", 6'h25);
        pulse_ack();
        check("s.pending_final", 32'(pending), 32'd0);

        // down_data holds while stalled.
        push(6'h0a);
        push(6'h2b);
        check("h.data0", 32'(down_data), 32'h0a);
        tick();
        check("h.data1", 32'(down_data), 32'h0a);
        pop_expect("h.pop0", 6'h0a);
        pop_expect("h.pop1", 6'h2b);
        pulse_ack();

        // Reset mid-replay.
        push(6'h06);
        push(6'h27);
        pop_expect("x0", 6'h06);
        pop_expect("x1", 6'h27);
        check("x.pending_pre_nack", 32'(pending), 32'd1);
        pulse_nack();
        check("x.valid_replay", 32'(down_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("x.down_valid", 32'(down_valid), 32'd0);
        check("x.pending", 32'(pending), 32'd0);
        check("x.up_ready", 32'(up_ready), 32'd1);
        push(6'h11);
        pop_expect("x.after_rst", 6'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
